// File: rtl/usb_data_tx.sv
// USB DATA packet transmitter: PID, LSB-first payload, then inverted CRC16.
// Keeps the DATA0/DATA1 toggle across packets; byte stream uses valid/ready.
module usb_data_tx #(
  parameter int         NUM_BYTES = 4,
  parameter logic [7:0] DATA0_PID = 8'hC3,
  parameter logic [7:0] DATA1_PID = 8'h4B
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   output_ready,
  input  logic [8*NUM_BYTES-1:0] average_data,
  output logic                   word_accept,
  output logic [7:0]             tx_byte,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   tx_last,
  output logic                   busy,
  input  logic                   clear_toggle,
  output logic                   data_toggle
);

  localparam int CW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PID,
    DATA,
    CRC_LO,
    CRC_HI
  } state_t;

  state_t                 state;
  logic [8*NUM_BYTES-1:0] word;
  logic [CW-1:0]          count;
  logic [15:0]            crc;
  logic [15:0]            crc_nxt;
  logic                   clr_pend;
  logic                   xfer;

  function automatic logic [15:0] crc_byte(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  // tx_byte holds the payload byte while in DATA, so it feeds the CRC
  assign crc_nxt     = crc_byte(crc, tx_byte);
  assign xfer        = tx_valid & tx_ready;
  assign word_accept = n_rst & (state == IDLE) & output_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      word        <= '0;
      count       <= '0;
      crc         <= 16'hFFFF;
      clr_pend    <= 1'b0;
      tx_byte     <= 8'h00;
      tx_valid    <= 1'b0;
      tx_last     <= 1'b0;
      busy        <= 1'b0;
      data_toggle <= 1'b0;
    end else begin
      if (state != IDLE && clear_toggle)
        clr_pend <= 1'b1;
      unique case (state)
        IDLE: begin
          clr_pend <= 1'b0;
          if (clear_toggle)
            data_toggle <= 1'b0;
          if (output_ready) begin
            word     <= average_data;
            crc      <= 16'hFFFF;
            tx_byte  <= (data_toggle && !clear_toggle) ?
                        DATA1_PID : DATA0_PID;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= PID;
          end
        end
        PID: begin
          if (xfer) begin
            count   <= '0;
            tx_byte <= word[7:0];
            state   <= DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            crc <= crc_nxt;
            if (count == LAST) begin
              tx_byte <= ~crc_nxt[7:0];
              state   <= CRC_LO;
            end else begin
              count   <= count + 1'b1;
              tx_byte <= word[8*(int'(count)+1) +: 8];
            end
          end
        end
        CRC_LO: begin
          if (xfer) begin
            tx_byte <= ~crc[15:8];
            tx_last <= 1'b1;
            state   <= CRC_HI;
          end
        end
        CRC_HI: begin
          if (xfer) begin
            tx_byte     <= 8'h00;
            tx_valid    <= 1'b0;
            tx_last     <= 1'b0;
            busy        <= 1'b0;
            data_toggle <= (clr_pend || clear_toggle) ?
                           1'b0 : ~data_toggle;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
